// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// The optional trailing checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   typedef logic [31:0] logic32;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      CHECK,
      DONE
   } loader_state_t;

   localparam logic [7:0] LOADER_START_BYTE = 8'hA5;

   // True when a requested word count does not fit in a 2^aw-word memory.
   function automatic logic count_exceeds(input logic [15:0] n, input int unsigned aw);
      return {1'b0, n} > (17'd1 << aw);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: three bytes are buffered and the fourth
// completes the word combinationally alongside a one-cycle word_valid.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       shift_en,
   input  logic [7:0] data_in,
   output logic       word_valid,
   output logic32     word
);

   logic [23:0] shift_reg;
   logic [1:0]  cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (clear) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[15:0], data_in};
         cnt_reg   <= cnt_reg + 2'd1;
      end
   end

   assign word_valid = shift_en && (cnt_reg == 2'd3);
   assign word       = {shift_reg, data_in};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes big-endian words into instruction memory
// and holds the core in reset while loading. Checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wd,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t FINAL_STATE = CHECK;
`else
   localparam loader_state_t FINAL_STATE = DONE;
`endif

   loader_state_t         state_reg, state_next;
   logic [7:0]            len_hi_reg;
   logic [15:0]           len_reg;
   logic [15:0]           word_idx_reg;
   logic                  cpu_hold_reg;
   logic                  error_reg;
   logic                  we_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic32                wd_reg;

   logic        accept;
   logic        frame_start;
   logic        set_error;
   logic        clear_hold;
   logic        shift_en;
   logic        word_valid;
   logic32      word;
   logic [15:0] len_in;
   logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_reg;
`endif

   assign in_ready  = (state_reg != DONE);
   assign done      = (state_reg == DONE);
   assign accept    = in_valid && in_ready;
   assign len_in    = {len_hi_reg, in_data};
   assign last_word = (word_idx_reg == len_reg - 16'd1);

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (frame_start),
      .shift_en   (shift_en),
      .data_in    (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      set_error   = 1'b0;
      shift_en    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept && in_data == LOADER_START_BYTE) begin
               state_next  = LEN_HI;
               frame_start = 1'b1;
            end
         end
         LEN_HI: begin
            if (accept) state_next = LEN_LO;
         end
         LEN_LO: begin
            if (accept) begin
               if (count_exceeds(len_in, ADDR_WIDTH)) begin
                  state_next = IDLE;
                  set_error  = 1'b1;
               end else if (len_in == 16'd0) begin
                  state_next = FINAL_STATE;
               end else begin
                  state_next = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            shift_en = accept;
            if (word_valid && last_word) state_next = FINAL_STATE;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) begin
               if (in_data == xor_reg) begin
                  state_next = DONE;
               end else begin
                  state_next = IDLE;
                  set_error  = 1'b1;
               end
            end
         end
`endif
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Hold drops together with the done pulse or on any abort.
      clear_hold = set_error || (state_next == DONE && state_reg != DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_reg   <= '0;
         len_reg      <= '0;
         word_idx_reg <= '0;
         cpu_hold_reg <= 1'b0;
         error_reg    <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= BASE;
         wd_reg       <= '0;
      end else begin
         we_reg <= word_valid;
         if (word_valid) begin
            wd_reg       <= word;
            addr_reg     <= BASE + word_idx_reg[ADDR_WIDTH-1:0];
            word_idx_reg <= word_idx_reg + 16'd1;
         end
         if (frame_start) begin
            cpu_hold_reg <= 1'b1;
            error_reg    <= 1'b0;
            word_idx_reg <= '0;
         end else if (clear_hold) begin
            cpu_hold_reg <= 1'b0;
         end
         if (set_error) error_reg <= 1'b1;
         if (state_reg == LEN_HI && accept) len_hi_reg <= in_data;
         if (state_reg == LEN_LO && accept) len_reg <= len_in;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_reg <= '0;
      end else if (frame_start) begin
         xor_reg <= '0;
      end else if (shift_en) begin
         xor_reg <= xor_reg ^ in_data;
      end
   end
`endif

   assign imem_we   = we_reg;
   assign imem_addr = addr_reg;
   assign imem_wd   = wd_reg;
   assign cpu_hold  = cpu_hold_reg;
   assign error     = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a
// frame-level reference model of expected writes, done and error.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int BASE  = 58;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wd;
   logic          cpu_hold;
   logic          done;
   logic          error;

   imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wd   (imem_wd),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int            cyc = 0;
   int            done_cnt = 0;
   logic [AW-1:0] wr_addr_q[$];
   logic32        wr_data_q[$];
   int            wr_cyc_q[$];
   logic32        words[$];
   int            n_pass = 0;
   int            n_fail = 0;
   int            n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wd);
         wr_cyc_q.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "/in_ready"}, 32'(in_ready), 1);
      chk({tag, "/imem_we"}, 32'(imem_we), 0);
      chk({tag, "/imem_addr"}, 32'(imem_addr), BASE);
      chk({tag, "/imem_wd"}, imem_wd, 0);
      chk({tag, "/cpu_hold"}, 32'(cpu_hold), 0);
      chk({tag, "/done"}, 32'(done), 0);
      chk({tag, "/error"}, 32'(error), 0);
   endtask

   // Present one byte and return at the falling edge right after it is taken.
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard = 0;
      if (stall) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_wait", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Build a frame from 'words' and count n, send it, and compare against
   // the frame-level expectations.
   task automatic run_frame(input logic [15:0] n, input bit bad_cks, input bit stall,
                            input string tag);
      logic [7:0] frame[$];
      logic [7:0] b;
      logic [7:0] cks = 8'h00;
      int         acc_q[$];
      bit         err_exp;
      int         nexp;
      int         d0;
      frame.push_back(LOADER_START_BYTE);
      frame.push_back(n[15:8]);
      frame.push_back(n[7:0]);
      foreach (words[i]) begin
         for (int k = 3; k >= 0; k--) begin
            b = words[i][8*k +: 8];
            frame.push_back(b);
            cks = cks ^ b;
         end
      end
      if (CKS && int'(n) <= DEPTH) frame.push_back(bad_cks ? ~cks : cks);
      err_exp = (int'(n) > DEPTH) || (CKS && bad_cks);
      nexp    = (int'(n) > DEPTH) ? 0 : int'(n);
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      d0 = done_cnt;
      foreach (frame[j]) begin
         send_byte(frame[j], stall);
         if (j == 0) chk({tag, "/hold_rise"}, 32'(cpu_hold), 1);
         if (j >= 3 && j < 3 + 4*nexp && (j - 3) % 4 == 3) acc_q.push_back(cyc);
      end
      chk({tag, "/done_end"}, 32'(done), 32'(!err_exp));
      chk({tag, "/hold_end"}, 32'(cpu_hold), 0);
      chk({tag, "/error_end"}, 32'(error), 32'(err_exp));
      chk({tag, "/ready_end"}, 32'(in_ready), 32'(err_exp));
      repeat (3) @(negedge clk);
      chk({tag, "/nwrites"}, 32'(wr_addr_q.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
         chk($sformatf("%s/addr%0d", tag, i), 32'(wr_addr_q[i]), 32'((BASE + i) % DEPTH));
         chk($sformatf("%s/data%0d", tag, i), wr_data_q[i], words[i]);
         chk($sformatf("%s/lat%0d", tag, i), 32'(wr_cyc_q[i]), 32'(acc_q[i]));
      end
      chk({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'(!err_exp));
      $display("frame %s: n=%0d writes=%0d error=%0b", tag, n, wr_addr_q.size(), error);
   endtask

   initial begin
      logic [15:0] n;
      logic [7:0]  part[6];

      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_values("post_reset");

      words = '{32'h20080005, 32'hAC090004};
      run_frame(16'd2, 1'b0, 1'b0, "two_word");
      run_frame(16'd2, 1'b0, 1'b1, "two_word_stalled");
`ifdef IMEM_LOADER_CHECKSUM_EN
      run_frame(16'd2, 1'b1, 1'b0, "bad_cks");
`endif

      words.delete();
      run_frame(16'h0041, 1'b0, 1'b0, "oversize");
      run_frame(16'h0000, 1'b0, 1'b0, "zero_len");

      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
      run_frame(16'd64, 1'b0, 1'b0, "full_depth");

      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h13, 1'b0);
      chk("junk/hold", 32'(cpu_hold), 0);
      words = '{32'h8C220010};
      run_frame(16'd1, 1'b0, 1'b0, "after_junk");

      for (int r = 0; r < 6; r++) begin
         words.delete();
         n = 16'($urandom_range(1, 12));
         for (int i = 0; i < int'(n); i++) words.push_back($urandom);
         run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", r));
      end

      part = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
      foreach (part[j]) send_byte(part[j], 1'b0);
      chk("mid/hold", 32'(cpu_hold), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_values("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      words = '{32'h20080005, 32'hAC090004};
      run_frame(16'd2, 1'b0, 1'b0, "reload");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
